pipelined_add_sub: RTL and testbench



---
 rtl/adder_pkg.sv | 27 ++
 rtl/adder_slice.sv | 23 ++
 rtl/pipelined_add_sub.sv | 153 +++++++++++++++
 tb/tb_pipelined_add_sub.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// The clamp helper is only referenced when ADDER_SAT_EN is defined.
package adder_pkg;

  localparam int SAT_MAX_WIDTH = 64;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

  // Signed limit for a given result width: min when neg_side is set, otherwise max.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_clamp(input int unsigned width,
                                                         input logic neg_side);
    logic [SAT_MAX_WIDTH-1:0] w_min;
    w_min = SAT_MAX_WIDTH'(1) << (width - 1);
    return neg_side ? w_min : (w_min - SAT_MAX_WIDTH'(1));
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder used as one pipeline slice.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_s,
  output logic         o_co
);

  logic [W:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_co = w_c[W];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub with the carry chain split across STAGES slices.
// Optional saturation (extra 'sat' input) is enabled by defining ADDER_SAT_EN.
module pipelined_add_sub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             cin,
`ifdef ADDER_SAT_EN
  input  logic             sat,
`endif
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = STAGES - 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  op_e w_op;
  logic w_advance;

  // Per-stage combinational view: operands/carry/partial sum entering stage k.
  logic [WIDTH-1:0] w_a     [STAGES];
  logic [WIDTH-1:0] w_b     [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic [WIDTH-1:0] w_s_out [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_vld_in[STAGES];
  logic [SLICE-1:0] w_slice_s [STAGES];
  logic             w_slice_co[STAGES];

  logic [WIDTH-1:0] r_a  [STAGES];
  logic [WIDTH-1:0] r_b  [STAGES];
  logic [WIDTH-1:0] r_sum[STAGES];
  logic             r_c  [STAGES];
  logic             r_vld[STAGES];
  alu_flags_t       r_flags;

`ifdef ADDER_SAT_EN
  logic w_sat_in[STAGES];
  logic r_sat   [STAGES];
`endif

  assign w_op      = op_e'(op);
  assign w_advance = !r_vld[LAST] || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtraction is a + ~b + !cin, so b and the carry are inverted up front.
      assign w_a[k]      = in_a;
      assign w_b[k]      = (w_op == OP_SUB) ? ~in_b : in_b;
      assign w_c_in[k]   = (w_op == OP_SUB) ? ~cin : cin;
      assign w_s_in[k]   = '0;
      assign w_vld_in[k] = in_valid;
`ifdef ADDER_SAT_EN
      assign w_sat_in[k] = sat;
`endif
    end else begin : g_body
      assign w_a[k]      = r_a[k-1];
      assign w_b[k]      = r_b[k-1];
      assign w_c_in[k]   = r_c[k-1];
      assign w_s_in[k]   = r_sum[k-1];
      assign w_vld_in[k] = r_vld[k-1];
`ifdef ADDER_SAT_EN
      assign w_sat_in[k] = r_sat[k-1];
`endif
    end

    adder_slice #(.W(SLICE)) u_slice (
      .i_a  (w_a[k][k*SLICE +: SLICE]),
      .i_b  (w_b[k][k*SLICE +: SLICE]),
      .i_ci (w_c_in[k]),
      .o_s  (w_slice_s[k]),
      .o_co (w_slice_co[k])
    );

    assign w_s_out[k] = (w_s_in[k] & ~(SLICE_MASK << (k * SLICE)))
                      | (WIDTH'(w_slice_s[k]) << (k * SLICE));
  end

  logic [WIDTH-1:0] w_raw_sum;
  logic [WIDTH-1:0] w_final_sum;
  logic             w_ovf;
  alu_flags_t       w_flags;

  assign w_raw_sum = w_s_out[LAST];
  assign w_ovf     = (w_a[LAST][MSB] == w_b[LAST][MSB]) && (w_raw_sum[MSB] != w_a[LAST][MSB]);

`ifdef ADDER_SAT_EN
  assign w_final_sum = (w_sat_in[LAST] && w_ovf) ? WIDTH'(sat_clamp(WIDTH, w_a[LAST][MSB]))
                                                 : w_raw_sum;
`else
  assign w_final_sum = w_raw_sum;
`endif

  assign w_flags = '{cout: w_slice_co[LAST],
                     ovf:  w_ovf,
                     zero: (w_final_sum == '0),
                     neg:  w_final_sum[MSB]};

  // The whole pipeline moves as one; a stall freezes every stage including the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_sum[k] <= '0;
`ifdef ADDER_SAT_EN
        r_sat[k] <= 1'b0;
`endif
      end
      r_flags <= '0;
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_a[k]   <= w_a[k];
        r_b[k]   <= w_b[k];
        r_c[k]   <= w_slice_co[k];
        r_sum[k] <= (k == LAST) ? w_final_sum : w_s_out[k];
`ifdef ADDER_SAT_EN
        r_sat[k] <= w_sat_in[k];
`endif
      end
      r_flags <= w_flags;
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = r_vld[LAST];
  assign sum       = r_sum[LAST];
  assign cout      = r_flags.cout;
  assign ovf       = r_flags.ovf;
  assign zero      = r_flags.zero;
  assign neg       = r_flags.neg;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub at WIDTH=8, STAGES=2.
// Saturation vectors are included when ADDER_SAT_EN is defined.
module tb_pipelined_add_sub;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic         cin;
  logic         sat;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  int tests = 0;
  int fails = 0;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .cin       (cin),
`ifdef ADDER_SAT_EN
    .sat       (sat),
`endif
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic         cin;
    logic         sat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } vec_t;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 1'b0; cin = 1'b0; sat = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    tests++; if (sum !== 8'h00) begin fails++; $display("FAIL reset sum got %h exp 00", sum); end
    tests++; if ({cout, ovf, zero, neg} !== 4'b0000) begin
      fails++; $display("FAIL reset flags got %b exp 0000", {cout, ovf, zero, neg});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset idle out_valid got %b exp 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_arith();
    vec_t v[11];
    int   n;
    v[0] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0};
    v[1] = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    v[2] = '{1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    v[3] = '{1'b1, 1'b0, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
    v[4] = '{1'b1, 1'b1, 1'b0, 8'h07, 8'h05, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    v[5] = '{1'b1, 1'b0, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    v[6] = '{1'b0, 1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    v[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    v[8] = '{1'b0, 1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    n = 9;
`ifdef ADDER_SAT_EN
    v[9]  = '{1'b0, 1'b0, 1'b1, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    v[10] = '{1'b1, 1'b0, 1'b1, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
    n = 11;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = v[i].op; cin = v[i].cin; sat = v[i].sat;
      in_a = v[i].a; in_b = v[i].b;
      @(posedge clk);
      #1 in_valid = 1'b0; sat = 1'b0;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arith[%0d] early out_valid got %b exp 0", i, out_valid); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL arith[%0d] out_valid got %b exp 1", i, out_valid); end
      tests++; if (sum !== v[i].sum) begin fails++; $display("FAIL arith[%0d] sum got %h exp %h", i, sum, v[i].sum); end
      tests++; if (cout !== v[i].cout) begin fails++; $display("FAIL arith[%0d] cout got %b exp %b", i, cout, v[i].cout); end
      tests++; if (ovf !== v[i].ovf) begin fails++; $display("FAIL arith[%0d] ovf got %b exp %b", i, ovf, v[i].ovf); end
      tests++; if (zero !== v[i].zero) begin fails++; $display("FAIL arith[%0d] zero got %b exp %b", i, zero, v[i].zero); end
      tests++; if (neg !== v[i].neg) begin fails++; $display("FAIL arith[%0d] neg got %b exp %b", i, neg, v[i].neg); end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic held_valid = 1'b0;
    logic [W-1:0] held_sum = '0;
    logic acc_in;
    while (recv < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 8) begin
        in_valid = 1'b1; op = 1'b0; cin = 1'b0; in_a = W'(sent); in_b = 8'h20;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall cyc%0d in_ready got %b exp 0", cyc, in_ready); end
      end
      if (held_valid) begin
        tests++; if (out_valid !== 1'b1 || sum !== held_sum) begin
          fails++; $display("FAIL stall cyc%0d hold got v=%b sum=%h exp v=1 sum=%h", cyc, out_valid, sum, held_sum);
        end
      end
      held_valid = out_valid && !out_ready;
      held_sum   = sum;
      acc_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        tests++; if (sum !== 8'h20 + W'(recv)) begin
          fails++; $display("FAIL stream beat%0d sum got %h exp %h", recv, sum, 8'h20 + W'(recv));
        end
        recv++;
      end
      @(posedge clk);
      if (acc_in) sent++;
      cyc++;
    end
    #1 in_valid = 1'b0; out_ready = 1'b1;
    tests++; if (recv != 8) begin fails++; $display("FAIL stream count got %0d exp 8", recv); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream extra beat cyc%0d out_valid got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = 1'b0; cin = 1'b0; in_a = 8'h11; in_b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    in_a = 8'h01; in_b = 8'h02;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset out_valid got %b exp 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset ghost cyc%0d out_valid got %b exp 0", i, out_valid); end
    end
    in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset early out_valid got %b exp 0", out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midreset next out_valid got %b exp 1", out_valid); end
    tests++; if (sum !== 8'h77) begin fails++; $display("FAIL midreset next sum got %h exp 77", sum); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
